bullcow_game_core_param: RTL and testbench

Parametrised two-player Bulls-and-Cows game engine. It is the next-generation replacement for the fixed 4-digit game logic beneath the top level, and feeds the display/LED driver. It adds:
- configurable digit count and digit range
- secret/guess validation with an error state
- a per-round try limit with try counter
- alternating setter role
- a match target score
- multi-cycle iterative scoring with a result strobe

---
 rtl/bullcow_game_core_param_if.sv | 33 +++
 rtl/bullcow_game_core_param.sv | 225 ++++++++++++++++++++++
 tb/tb_bullcow_game_core_param.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bullcow_game_core_param_if.sv
// rtl/bullcow_game_core_param_if.sv - player input and game status bundle for the bulls-and-cows core
interface bullcow_game_core_param_if #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int MAX_TRIES  = 8,
  parameter int POINTS_W   = 8
) ();
  localparam int BC_W = $clog2(NUM_DIGITS + 1);
  localparam int T_W  = $clog2(MAX_TRIES + 1);

  logic                          enter;
  logic [NUM_DIGITS*DIGIT_W-1:0] sw;
  logic [POINTS_W-1:0]           j1_points;
  logic [POINTS_W-1:0]           j2_points;
  logic [BC_W-1:0]               bull_count;
  logic [BC_W-1:0]               cow_count;
  logic [T_W-1:0]                tries_left;
  logic                          setter;
  logic [2:0]                    game_state;
  logic                          result_valid;

  modport master (
    output enter, sw,
    input  j1_points, j2_points, bull_count, cow_count,
           tries_left, setter, game_state, result_valid
  );

  modport slave (
    input  enter, sw,
    output j1_points, j2_points, bull_count, cow_count,
           tries_left, setter, game_state, result_valid
  );
endinterface

// File: rtl/bullcow_game_core_param.sv
// rtl/bullcow_game_core_param.sv - parametrised two-player bulls-and-cows engine
// Scores one guess digit per cycle; every output comes straight from a register.
module bullcow_game_core_param #(
  parameter int NUM_DIGITS = 4,
  parameter int DIGIT_W    = 4,
  parameter int DIGIT_MAX  = 9,
  parameter int MAX_TRIES  = 8,
  parameter int WIN_POINTS = 3,
  parameter int POINTS_W   = 8
) (
  input logic                       clock,
  input logic                       reset,
  bullcow_game_core_param_if.slave  bus
);
  localparam int BC_W  = $clog2(NUM_DIGITS + 1);
  localparam int T_W   = $clog2(MAX_TRIES + 1);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int VEC_W = NUM_DIGITS * DIGIT_W;

  typedef enum logic [2:0] {
    S_SETUP      = 3'd0,
    S_GUESS      = 3'd1,
    S_SCORE      = 3'd2,
    S_RESULT     = 3'd3,
    S_ROUND_WIN  = 3'd4,
    S_ROUND_LOSS = 3'd5,
    S_MATCH_OVER = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  state_t              state_q, state_d;
  logic                enter_q;
  logic                setter_q, setter_d;
  logic [POINTS_W-1:0] j1_q, j1_d, j2_q, j2_d;
  logic [BC_W-1:0]     bull_q, bull_d, cow_q, cow_d;
  logic [BC_W-1:0]     bull_acc_q, bull_acc_d, cow_acc_q, cow_acc_d;
  logic [T_W-1:0]      tries_q, tries_d;
  logic                rv_q, rv_d;
  logic [VEC_W-1:0]    secret_q, secret_d, guess_q, guess_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                err_to_guess_q, err_to_guess_d;

  logic                press;
  logic                sw_valid;
  logic [DIGIT_W-1:0]  cur_g, cur_s;
  logic                hit_bull, hit_cow;
  logic [BC_W-1:0]     bull_sum, cow_sum;

  function automatic logic [DIGIT_W-1:0] dig(input logic [VEC_W-1:0] v, input int k);
    return v[k*DIGIT_W +: DIGIT_W];
  endfunction

  assign press = bus.enter & ~enter_q;

  always_comb begin
    sw_valid = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig(bus.sw, k) > DIGIT_W'(DIGIT_MAX)) sw_valid = 1'b0;
      for (int j = k + 1; j < NUM_DIGITS; j++) begin
        if (dig(bus.sw, k) == dig(bus.sw, j)) sw_valid = 1'b0;
      end
    end
  end

  // Compare the guess digit at idx against the whole secret in one cycle.
  always_comb begin
    cur_g   = '0;
    cur_s   = '0;
    hit_cow = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        cur_g = dig(guess_q, k);
        cur_s = dig(secret_q, k);
      end
    end
    hit_bull = (cur_g == cur_s);
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q != IDX_W'(k) && dig(secret_q, k) == cur_g) hit_cow = 1'b1;
    end
    bull_sum = bull_acc_q + BC_W'(hit_bull);
    cow_sum  = cow_acc_q + BC_W'(hit_cow);
  end

  always_comb begin
    state_d        = state_q;
    setter_d       = setter_q;
    j1_d           = j1_q;
    j2_d           = j2_q;
    bull_d         = bull_q;
    cow_d          = cow_q;
    bull_acc_d     = bull_acc_q;
    cow_acc_d      = cow_acc_q;
    tries_d        = tries_q;
    rv_d           = 1'b0;
    secret_d       = secret_q;
    guess_d        = guess_q;
    idx_d          = idx_q;
    err_to_guess_d = err_to_guess_q;

    case (state_q)
      S_SETUP: begin
        if (press) begin
          if (sw_valid) begin
            secret_d = bus.sw;
            tries_d  = T_W'(MAX_TRIES);
            state_d  = S_GUESS;
          end else begin
            err_to_guess_d = 1'b0;
            state_d        = S_ERROR;
          end
        end
      end
      S_GUESS: begin
        if (press) begin
          if (sw_valid) begin
            guess_d    = bus.sw;
            idx_d      = '0;
            bull_acc_d = '0;
            cow_acc_d  = '0;
            state_d    = S_SCORE;
          end else begin
            err_to_guess_d = 1'b1;
            state_d        = S_ERROR;
          end
        end
      end
      S_SCORE: begin
        if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
          bull_d  = bull_sum;
          cow_d   = cow_sum;
          tries_d = tries_q - T_W'(1);
          rv_d    = 1'b1;
          if (bull_sum == BC_W'(NUM_DIGITS)) begin
            state_d = S_ROUND_WIN;
            if (!setter_q && j2_q < POINTS_W'(WIN_POINTS)) j2_d = j2_q + POINTS_W'(1);
            if (setter_q && j1_q < POINTS_W'(WIN_POINTS))  j1_d = j1_q + POINTS_W'(1);
          end else if (tries_q == T_W'(1)) begin
            state_d = S_ROUND_LOSS;
            if (!setter_q && j1_q < POINTS_W'(WIN_POINTS)) j1_d = j1_q + POINTS_W'(1);
            if (setter_q && j2_q < POINTS_W'(WIN_POINTS))  j2_d = j2_q + POINTS_W'(1);
          end else begin
            state_d = S_RESULT;
          end
        end else begin
          idx_d      = idx_q + IDX_W'(1);
          bull_acc_d = bull_sum;
          cow_acc_d  = cow_sum;
        end
      end
      S_RESULT: begin
        if (press) state_d = S_GUESS;
      end
      S_ROUND_WIN, S_ROUND_LOSS: begin
        if (press) begin
          if (j1_q == POINTS_W'(WIN_POINTS) || j2_q == POINTS_W'(WIN_POINTS)) begin
            state_d = S_MATCH_OVER;
          end else begin
            setter_d = ~setter_q;
            state_d  = S_SETUP;
          end
        end
      end
      S_MATCH_OVER: begin
        if (press) begin
          j1_d     = '0;
          j2_d     = '0;
          bull_d   = '0;
          cow_d    = '0;
          setter_d = 1'b0;
          tries_d  = T_W'(MAX_TRIES);
          state_d  = S_SETUP;
        end
      end
      S_ERROR: begin
        if (press) state_d = err_to_guess_q ? S_GUESS : S_SETUP;
      end
      default: state_d = S_SETUP;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= S_SETUP;
      enter_q        <= 1'b0;
      setter_q       <= 1'b0;
      j1_q           <= '0;
      j2_q           <= '0;
      bull_q         <= '0;
      cow_q          <= '0;
      bull_acc_q     <= '0;
      cow_acc_q      <= '0;
      tries_q        <= T_W'(MAX_TRIES);
      rv_q           <= 1'b0;
      secret_q       <= '0;
      guess_q        <= '0;
      idx_q          <= '0;
      err_to_guess_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      enter_q        <= bus.enter;
      setter_q       <= setter_d;
      j1_q           <= j1_d;
      j2_q           <= j2_d;
      bull_q         <= bull_d;
      cow_q          <= cow_d;
      bull_acc_q     <= bull_acc_d;
      cow_acc_q      <= cow_acc_d;
      tries_q        <= tries_d;
      rv_q           <= rv_d;
      secret_q       <= secret_d;
      guess_q        <= guess_d;
      idx_q          <= idx_d;
      err_to_guess_q <= err_to_guess_d;
    end
  end

  assign bus.j1_points    = j1_q;
  assign bus.j2_points    = j2_q;
  assign bus.bull_count   = bull_q;
  assign bus.cow_count    = cow_q;
  assign bus.tries_left   = tries_q;
  assign bus.setter       = setter_q;
  assign bus.game_state   = state_q;
  assign bus.result_valid = rv_q;
endmodule

// File: tb/tb_bullcow_game_core_param.sv
// tb/tb_bullcow_game_core_param.sv - directed self-checking bench for bullcow_game_core_param
module tb_bullcow_game_core_param;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  bullcow_game_core_param_if #(.NUM_DIGITS(4), .DIGIT_W(4), .MAX_TRIES(8), .POINTS_W(8)) bus ();

  bullcow_game_core_param #(
    .NUM_DIGITS(4), .DIGIT_W(4), .DIGIT_MAX(9),
    .MAX_TRIES(8), .WIN_POINTS(3), .POINTS_W(8)
  ) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press_and_release();
    @(negedge clk);
    bus.enter = 1'b1;
    @(negedge clk);
    bus.enter = 1'b0;
  endtask

  task automatic do_guess(input logic [15:0] val);
    bus.sw = val;
    press_and_release();
    repeat (4) @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int trans;
    logic [2:0] prev;
    rst_n     = 1'b0;
    bus.enter = 1'b0;
    bus.sw    = '0;

    // 1: reset values
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_state", bus.game_state, 0);
    chk("rst_setter", bus.setter, 0);
    chk("rst_j1", bus.j1_points, 0);
    chk("rst_j2", bus.j2_points, 0);
    chk("rst_bull", bus.bull_count, 0);
    chk("rst_cow", bus.cow_count, 0);
    chk("rst_tries", bus.tries_left, 8);
    chk("rst_rv", bus.result_valid, 0);

    // 2: setup then one scored guess with latency check
    bus.sw = 16'h1234;
    press_and_release();
    chk("setup_state", bus.game_state, 1);
    bus.sw = 16'h1243;
    press_and_release();
    chk("score_c1", bus.game_state, 2);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("score_cn", bus.game_state, 2);
      chk("score_rv_low", bus.result_valid, 0);
    end
    @(negedge clk);
    chk("g1_bull", bus.bull_count, 2);
    chk("g1_cow", bus.cow_count, 2);
    chk("g1_tries", bus.tries_left, 7);
    chk("g1_rv", bus.result_valid, 1);
    chk("g1_state", bus.game_state, 3);
    @(negedge clk);
    chk("g1_rv_pulse", bus.result_valid, 0);

    // 3: invalid guess and invalid secrets
    press_and_release();
    chk("res_to_guess", bus.game_state, 1);
    bus.sw = 16'h5565;
    press_and_release();
    chk("bad_guess_err", bus.game_state, 7);
    press_and_release();
    chk("err_to_guess", bus.game_state, 1);
    chk("err_tries", bus.tries_left, 7);
    chk("err_bull_hold", bus.bull_count, 2);
    apply_reset();
    bus.sw = 16'h1123;
    press_and_release();
    chk("dup_secret_err", bus.game_state, 7);
    press_and_release();
    chk("err_to_setup", bus.game_state, 0);
    bus.sw = 16'h12A4;
    press_and_release();
    chk("range_secret_err", bus.game_state, 7);
    press_and_release();
    chk("err_to_setup2", bus.game_state, 0);

    // 4: round win
    bus.sw = 16'h1234;
    press_and_release();
    do_guess(16'h1234);
    chk("win_bull", bus.bull_count, 4);
    chk("win_cow", bus.cow_count, 0);
    chk("win_state", bus.game_state, 4);
    chk("win_j2", bus.j2_points, 1);
    chk("win_j1", bus.j1_points, 0);
    press_and_release();
    chk("win_next_state", bus.game_state, 0);
    chk("win_setter", bus.setter, 1);

    // 5: round loss after MAX_TRIES misses
    apply_reset();
    bus.sw = 16'h1234;
    press_and_release();
    for (int i = 0; i < 8; i++) begin
      do_guess(16'h5678);
      chk("loss_bull", bus.bull_count, 0);
      chk("loss_cow", bus.cow_count, 0);
      chk("loss_tries", bus.tries_left, 7 - i);
      if (i < 7) begin
        chk("loss_mid_state", bus.game_state, 3);
        press_and_release();
      end
    end
    chk("loss_state", bus.game_state, 5);
    chk("loss_j1", bus.j1_points, 1);
    chk("loss_j2", bus.j2_points, 0);

    // 6: J2 reaches WIN_POINTS via win, setter-loss, win
    apply_reset();
    bus.sw = 16'h1234;
    press_and_release();
    do_guess(16'h1234);
    chk("m_r1_j2", bus.j2_points, 1);
    press_and_release();
    chk("m_r1_setter", bus.setter, 1);
    bus.sw = 16'h9876;
    press_and_release();
    for (int i = 0; i < 8; i++) begin
      do_guess(16'h0123);
      if (i < 7) press_and_release();
    end
    chk("m_r2_state", bus.game_state, 5);
    chk("m_r2_j2", bus.j2_points, 2);
    chk("m_r2_j1", bus.j1_points, 0);
    press_and_release();
    chk("m_r2_setter", bus.setter, 0);
    bus.sw = 16'h3579;
    press_and_release();
    do_guess(16'h3579);
    chk("m_r3_state", bus.game_state, 4);
    chk("m_r3_j2", bus.j2_points, 3);
    press_and_release();
    chk("match_over", bus.game_state, 6);
    chk("match_j2_hold", bus.j2_points, 3);

    // enter held high yields one press
    @(negedge clk);
    bus.enter = 1'b1;
    prev  = bus.game_state;
    trans = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.game_state !== prev) trans++;
      prev = bus.game_state;
    end
    bus.enter = 1'b0;
    @(negedge clk);
    chk("held_one_trans", trans, 1);
    chk("clr_state", bus.game_state, 0);
    chk("clr_j2", bus.j2_points, 0);
    chk("clr_bull", bus.bull_count, 0);
    chk("clr_setter", bus.setter, 0);

    // reset asserted in the middle of SCORE
    bus.sw = 16'h1234;
    press_and_release();
    do_guess(16'h1243);
    chk("pre_rst_bull", bus.bull_count, 2);
    press_and_release();
    bus.sw = 16'h1235;
    press_and_release();
    @(negedge clk);
    chk("pre_rst_score", bus.game_state, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_state", bus.game_state, 0);
    chk("mid_rst_bull", bus.bull_count, 0);
    chk("mid_rst_cow", bus.cow_count, 0);
    chk("mid_rst_tries", bus.tries_left, 8);
    chk("mid_rst_rv", bus.result_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_state", bus.game_state, 0);
    chk("post_rst_rv", bus.result_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
